// File: rtl/console_pkg.sv
// Shared console (DLART) definitions: transmit FSM states, register
// addresses, the bus INIT GP code and the default FIFO depth.
`timescale 1ns/1ps

package console_pkg;

    localparam int CONSOLE_FIFO_DEPTH = 16;

    localparam logic [21:0] RCSR_ADDR = 22'o17777560;
    localparam logic [21:0] RBUF_ADDR = 22'o17777562;
    localparam logic [21:0] XCSR_ADDR = 22'o17777564;
    localparam logic [21:0] XBUF_ADDR = 22'o17777566;

    localparam logic [7:0] GP_INIT = 8'o014;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        RECOVER
    } tx_state_t;

endpackage

// File: rtl/console_fifo.sv
// Single-clock byte FIFO with async reset and synchronous clear. The caller
// qualifies push against full; the receive path reuses this block.
`timescale 1ns/1ps

module console_fifo
    import console_pkg::*;
#(
    parameter int DEPTH = CONSOLE_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    pop_data,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   LVL_ONE    = (AW + 1)'(1);
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)      level_d = level_q + LVL_ONE;
            else if (!push && pop) level_d = level_q - LVL_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign level    = level_q;
    assign full     = (level_q == FULL_LEVEL);
    assign empty    = (level_q == '0);

endmodule

// File: rtl/console_tx_bridge.sv
// Console transmit bridge: buffers XBUF bytes and hands them to the host over
// the ODT rstb/rrdy handshake. Define CONSOLE_TX_TIMEOUT_EN for a STROBE timeout.
`timescale 1ns/1ps

module console_tx_bridge
    import console_pkg::*;
#(
    parameter int DEPTH = CONSOLE_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
`ifdef CONSOLE_TX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1_000_000
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rrdy,
    output logic          rstb,
    output logic [7:0]    ad_out,
    output logic          ad_oe,
    output logic          tx_ready,
    output logic          tx_empty,
    output logic          ovf,
    output logic [AW:0]   level
);

    tx_state_t  state_q, state_d;
    logic       rrdy_meta_q, rrdy_s_q;
    logic [7:0] ad_out_q, ad_out_d;
    logic       ovf_q, ovf_d;
    logic       push, pop, fifo_full, fifo_empty, tmo_fire;
    logic [7:0] head_data;

    console_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .push     (push),
        .push_data(wr_data),
        .pop      (pop),
        .pop_data (head_data),
        .level    (level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign pop  = (state_q == IDLE) && !fifo_empty && rrdy_s_q && !flush;
    assign push = wr_en && !flush && (!fifo_full || pop);

`ifdef CONSOLE_TX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_ONE  = CW'(1);

    logic [CW-1:0] tmo_q, tmo_d;

    // A normal rrdy fall takes priority over an expiry in the same cycle.
    assign tmo_fire = (state_q == STROBE) && rrdy_s_q && (tmo_q == '0);

    always_comb begin
        tmo_d = tmo_q;
        if (flush)                                   tmo_d = '0;
        else if (pop)                                tmo_d = TMO_LOAD;
        else if (state_q == STROBE && tmo_q != '0)   tmo_d = tmo_q - TMO_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    assign tmo_fire = 1'b0;
`endif

    always_comb begin
        ad_out_d = pop ? head_data : ad_out_q;
        ovf_d    = flush ? 1'b0 : (ovf_q | (wr_en && !push) | tmo_fire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrdy_meta_q <= 1'b0;
            rrdy_s_q    <= 1'b0;
            ad_out_q    <= 8'h00;
            ovf_q       <= 1'b0;
            state_q     <= IDLE;
        end else begin
            rrdy_meta_q <= rrdy;
            rrdy_s_q    <= rrdy_meta_q;
            ad_out_q    <= ad_out_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
        end
    end

    // RECOVER waits for rrdy to return high so a stale low never re-strobes.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (pop) state_d = STROBE;
                STROBE:  if (!rrdy_s_q || tmo_fire) state_d = RECOVER;
                RECOVER: if (rrdy_s_q) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rstb     = (state_q == STROBE);
        ad_oe    = (state_q == STROBE);
        ad_out   = ad_out_q;
        ovf      = ovf_q;
        tx_ready = !fifo_full;
        tx_empty = fifo_empty && (state_q == IDLE);
    end

endmodule
